// File: rtl/dma_rx_ctrl_pkg.sv
// Shared definitions for the DMA receive path: FSM encodings and datapath widths.
package dma_rx_ctrl_pkg;

    localparam int LANE_WIDTH = 32;
    localparam int WORD_WIDTH = 128;
    localparam int LANES      = WORD_WIDTH / LANE_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo128.sv
// First-word-fall-through buffer of 128-bit words; empty reads present zero.
module sync_fifo128
    import dma_rx_ctrl_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                  pl_clk,
    input  logic                  nreset,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WORD_WIDTH-1:0] din,
    output logic [WORD_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge pl_clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the empty mask on dout hides stale contents.
    always_ff @(posedge pl_clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/dma_rx_ctrl.sv
// Receives a 32-bit AXI-Stream from the DMA, packs four beats per 128-bit word
// and buffers the words for the CPU.
module dma_rx_ctrl
    import dma_rx_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_BEATS  = 32768
) (
    input  logic         pl_clk,
    input  logic         nreset,
    input  logic         fifo_reset,
    input  logic         dma_start,
    input  logic [31:0]  s_tdata,
    input  logic [3:0]   s_tkeep,
    input  logic         s_tlast,
    input  logic         s_tvalid,
    output logic         s_tready,
    output logic [127:0] dma_out,
    output logic         dma_valid,
    input  logic         dma_re,
    output logic [31:0]  word_count,
    output logic         frame_err,
    output logic [11:0]  led
);

    localparam int BEAT_W = $clog2(MAX_BEATS + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);

    state_t                state;
    state_t                state_next;
    logic [1:0]            lane;
    logic [LANE_WIDTH-1:0] held [LANES];
    logic [BEAT_W-1:0]     beat_cnt;
    logic [WORD_WIDTH-1:0] push_word;
    logic                  accept;
    logic                  at_max;
    logic                  last_beat;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;

    assign s_tready  = (state == RECV) && dma_start && !fifo_full;
    assign accept    = s_tvalid && s_tready;
    assign at_max    = (beat_cnt == LAST_BEAT);
    assign last_beat = s_tlast || at_max;
    assign push      = accept && !fifo_reset && ((lane == 2'd3) || last_beat);
    assign pop       = dma_re && dma_valid;
    assign dma_valid = !fifo_empty;

    assign led = {word_count[3:0], state, fifo_full, !dma_valid,
                  dma_start, s_tvalid, s_tready, frame_err};

    always_ff @(posedge pl_clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (fifo_reset) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (dma_start) state_next = RECV;
                RECV: begin
                    if (accept && last_beat) begin
                        state_next = DONE;
                    end else if (!dma_start) begin
                        state_next = IDLE;
                    end
                end
                DONE: if (!dma_start) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Earlier lanes come from the holding registers, the current beat goes
    // straight into its lane, and lanes not yet reached stay zero.
    always_comb begin
        push_word = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i < int'(lane)) begin
                push_word[i*LANE_WIDTH +: LANE_WIDTH] = held[i];
            end else if (i == int'(lane)) begin
                push_word[i*LANE_WIDTH +: LANE_WIDTH] = s_tdata;
            end
        end
    end

    // Any exit from RECV (frame end, abort, clear) restarts packing at lane 0.
    always_ff @(posedge pl_clk or negedge nreset) begin
        if (!nreset) begin
            lane     <= 2'd0;
            beat_cnt <= '0;
        end else if (state_next != RECV) begin
            lane     <= 2'd0;
            beat_cnt <= '0;
        end else if (accept) begin
            lane     <= lane + 2'd1;
            beat_cnt <= beat_cnt + BEAT_W'(1);
        end
    end

    always_ff @(posedge pl_clk) begin
        if (accept) begin
            held[lane] <= s_tdata;
        end
    end

    always_ff @(posedge pl_clk or negedge nreset) begin
        if (!nreset) begin
            frame_err <= 1'b0;
        end else if (fifo_reset) begin
            frame_err <= 1'b0;
        end else if (accept && ((s_tkeep != 4'hF) || (at_max && !s_tlast))) begin
            frame_err <= 1'b1;
        end
    end

    always_ff @(posedge pl_clk or negedge nreset) begin
        if (!nreset) begin
            word_count <= '0;
        end else if (push) begin
            word_count <= word_count + 32'd1;
        end
    end

    sync_fifo128 #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .pl_clk(pl_clk),
        .nreset(nreset),
        .clear (fifo_reset),
        .push  (push),
        .pop   (pop),
        .din   (push_word),
        .dout  (dma_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_dma_rx_ctrl.sv
// Directed plus randomized bench for dma_rx_ctrl against a queue-based frame model.
module tb_dma_rx_ctrl;

    localparam int DEPTH = 16;
    localparam int MB    = 102;

    logic         pl_clk;
    logic         nreset;
    logic         fifo_reset;
    logic         dma_start;
    logic [31:0]  s_tdata;
    logic [3:0]   s_tkeep;
    logic         s_tlast;
    logic         s_tvalid;
    logic         s_tready;
    logic [127:0] dma_out;
    logic         dma_valid;
    logic         dma_re;
    logic [31:0]  word_count;
    logic         frame_err;
    logic [11:0]  led;

    dma_rx_ctrl #(
        .FIFO_DEPTH(DEPTH),
        .MAX_BEATS (MB)
    ) dut (
        .pl_clk    (pl_clk),
        .nreset    (nreset),
        .fifo_reset(fifo_reset),
        .dma_start (dma_start),
        .s_tdata   (s_tdata),
        .s_tkeep   (s_tkeep),
        .s_tlast   (s_tlast),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .dma_out   (dma_out),
        .dma_valid (dma_valid),
        .dma_re    (dma_re),
        .word_count(word_count),
        .frame_err (frame_err),
        .led       (led)
    );

    initial pl_clk = 1'b0;
    always #5 pl_clk = ~pl_clk;

    logic [127:0] q [$];
    logic [31:0]  part [$];
    logic [1:0]   m_state;
    int           m_beats;
    logic [31:0]  m_wc;
    logic         m_err;
    logic         m_acc;
    int           total;
    int           bad;

    function automatic logic m_ready();
        return (m_state == 2'd1) && dma_start && (q.size() < DEPTH);
    endfunction

    task automatic model_reset();
        q.delete();
        part.delete();
        m_state = 2'd0;
        m_beats = 0;
        m_wc    = 32'd0;
        m_err   = 1'b0;
        m_acc   = 1'b0;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        logic [127:0] head;
        logic [11:0]  exp_led;
        head    = (q.size() > 0) ? q[0] : 128'd0;
        exp_led = {m_wc[3:0], m_state, q.size() == DEPTH, q.size() == 0,
                   dma_start, s_tvalid, m_ready(), m_err};
        check("s_tready",   128'(s_tready),   128'(m_ready()));
        check("dma_valid",  128'(dma_valid),  128'(q.size() > 0));
        check("dma_out",    dma_out,          head);
        check("word_count", 128'(word_count), 128'(m_wc));
        check("frame_err",  128'(frame_err),  128'(m_err));
        check("led",        128'(led),        128'(exp_led));
    endtask

    // Frame rules applied with the inputs seen at the clock edge.
    task automatic model_update(input logic rdy);
        logic         fin;
        logic [127:0] w;
        m_acc = 1'b0;
        fin   = 1'b0;
        if (!nreset) begin
            model_reset();
        end else if (fifo_reset) begin
            q.delete();
            part.delete();
            m_err   = 1'b0;
            m_state = 2'd0;
            m_beats = 0;
        end else begin
            if (dma_re && q.size() > 0) void'(q.pop_front());
            if (s_tvalid && rdy) begin
                m_acc = 1'b1;
                part.push_back(s_tdata);
                m_beats++;
                if (s_tkeep != 4'hF) m_err = 1'b1;
                if (m_beats == MB && !s_tlast) m_err = 1'b1;
                fin = s_tlast || (m_beats == MB);
                if (part.size() == 4 || fin) begin
                    w = '0;
                    foreach (part[i]) w[32*i +: 32] = part[i];
                    q.push_back(w);
                    m_wc++;
                    part.delete();
                end
            end
            case (m_state)
                2'd0: if (dma_start) m_state = 2'd1;
                2'd1: begin
                    if (fin) begin
                        m_state = 2'd2;
                        m_beats = 0;
                    end else if (!dma_start) begin
                        m_state = 2'd0;
                        m_beats = 0;
                        part.delete();
                    end
                end
                default: if (!dma_start) m_state = 2'd0;
            endcase
        end
    endtask

    task automatic tick();
        logic rdy;
        #1;
        check_output();
        rdy = m_ready();
        @(posedge pl_clk);
        model_update(rdy);
        @(negedge pl_clk);
    endtask

    task automatic apply_stimulus(input logic v, input logic [31:0] d, input logic [3:0] k,
                                  input logic l, input logic re);
        s_tvalid = v;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        dma_re   = re;
        tick();
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        logic got;
        got      = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        for (int n = 0; n < 100 && !got; n++) begin
            tick();
            got = m_acc;
        end
        check("beat_accept", 128'(got), 128'(1));
    endtask

    task automatic drain();
        s_tvalid = 1'b0;
        dma_re   = 1'b1;
        for (int n = 0; n < 40 && q.size() > 0; n++) tick();
        dma_re = 1'b0;
        #1;
        check("drain_empty", 128'(dma_valid), 128'(0));
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        nreset     = 1'b0;
        fifo_reset = 1'b0;
        dma_start  = 1'b0;
        s_tdata    = '0;
        s_tkeep    = 4'hF;
        s_tlast    = 1'b0;
        s_tvalid   = 1'b0;
        dma_re     = 1'b0;
        model_reset();
        #1;
        check_output();
        repeat (2) @(negedge pl_clk);
        nreset = 1'b1;
        apply_stimulus(1'b0, 32'd0, 4'hF, 1'b0, 1'b0);

        $display("[TB] eight-beat frame");
        dma_start = 1'b1;
        tick();
        for (int b = 1; b <= 8; b++) send_beat(32'(b), 4'hF, b == 8);
        apply_stimulus(1'b0, 32'd0, 4'hF, 1'b0, 1'b0);
        #1;
        check("w0", dma_out, 128'h00000004_00000003_00000002_00000001);
        check("wc2", 128'(word_count), 128'(2));
        check("done", 128'(led[7:6]), 128'(2));
        apply_stimulus(1'b0, 32'd0, 4'hF, 1'b0, 1'b1);
        dma_re = 1'b0;
        #1;
        check("w1", dma_out, 128'h00000008_00000007_00000006_00000005);
        dma_start = 1'b0;
        drain();

        $display("[TB] six-beat frame");
        dma_start = 1'b1;
        tick();
        for (int b = 1; b <= 6; b++) send_beat(32'(b), 4'hF, b == 6);
        apply_stimulus(1'b0, 32'd0, 4'hF, 1'b0, 1'b1);
        dma_re = 1'b0;
        #1;
        check("w_short", dma_out, 128'h00000000_00000000_00000006_00000005);
        dma_start = 1'b0;
        drain();

        $display("[TB] aborted frame");
        dma_start = 1'b1;
        tick();
        send_beat(32'hDEAD0001, 4'hF, 1'b0);
        send_beat(32'hDEAD0002, 4'hF, 1'b0);
        dma_start = 1'b0;
        apply_stimulus(1'b0, 32'd0, 4'hF, 1'b0, 1'b0);
        #1;
        check("abort_novalid", 128'(dma_valid), 128'(0));
        check("abort_idle", 128'(led[7:6]), 128'(0));
        dma_start = 1'b1;
        tick();
        for (int b = 0; b < 4; b++) send_beat(32'hA + 32'(b), 4'hF, b == 3);
        apply_stimulus(1'b0, 32'd0, 4'hF, 1'b0, 1'b0);
        #1;
        check("restart_lane0", dma_out, 128'h0000000D_0000000C_0000000B_0000000A);
        dma_start = 1'b0;
        drain();

        $display("[TB] keep error and clear");
        dma_start = 1'b1;
        tick();
        send_beat(32'h11, 4'h7, 1'b0);
        for (int b = 0; b < 3; b++) send_beat(32'h12 + 32'(b), 4'hF, 1'b0);
        apply_stimulus(1'b0, 32'd0, 4'hF, 1'b0, 1'b0);
        apply_stimulus(1'b0, 32'd0, 4'hF, 1'b0, 1'b0);
        #1;
        check("err_held", 128'(frame_err), 128'(1));
        fifo_reset = 1'b1;
        tick();
        fifo_reset = 1'b0;
        #1;
        check("clr_err", 128'(frame_err), 128'(0));
        check("clr_valid", 128'(dma_valid), 128'(0));

        $display("[TB] backpressure");
        tick();
        for (int b = 0; b < 64; b++) send_beat(32'h100 + 32'(b), 4'hF, 1'b0);
        apply_stimulus(1'b1, 32'h140, 4'hF, 1'b0, 1'b0);
        #1;
        check("full_stall", 128'(s_tready), 128'(0));
        apply_stimulus(1'b1, 32'h140, 4'hF, 1'b0, 1'b1);
        dma_re = 1'b0;
        #1;
        check("full_resume", 128'(s_tready), 128'(1));
        send_beat(32'h140, 4'hF, 1'b0);
        send_beat(32'h141, 4'hF, 1'b0);
        send_beat(32'h142, 4'hF, 1'b1);
        drain();
        dma_start = 1'b0;
        tick();

        $display("[TB] beat limit");
        dma_start = 1'b1;
        dma_re    = 1'b1;
        tick();
        for (int b = 0; b < MB; b++) send_beat(32'h5000 + 32'(b), 4'hF, 1'b0);
        apply_stimulus(1'b0, 32'd0, 4'hF, 1'b0, 1'b0);
        #1;
        check("limit_err", 128'(frame_err), 128'(1));
        check("limit_done", 128'(led[7:6]), 128'(2));
        drain();
        dma_start = 1'b0;
        tick();

        $display("[TB] reset mid-frame");
        dma_start = 1'b1;
        tick();
        for (int b = 0; b < 14; b++) send_beat(32'h7000 + 32'(b), 4'hF, 1'b0);
        nreset = 1'b0;
        model_reset();
        #1;
        check("rst_valid", 128'(dma_valid), 128'(0));
        check("rst_wc", 128'(word_count), 128'(0));
        dma_start = 1'b0;
        apply_stimulus(1'b0, 32'd0, 4'hF, 1'b0, 1'b0);
        nreset = 1'b1;
        apply_stimulus(1'b0, 32'd0, 4'hF, 1'b0, 1'b0);
        #1;
        check("rst_idle", 128'(led[7:6]), 128'(0));

        $display("[TB] random traffic");
        dma_start = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 49) == 0) dma_start = ~dma_start;
            fifo_reset = ($urandom_range(0, 199) == 0);
            apply_stimulus($urandom_range(0, 3) != 0, $urandom,
                           ($urandom_range(0, 29) == 0) ? 4'h3 : 4'hF,
                           $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
        end
        fifo_reset = 1'b0;
        dma_start  = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_rx_ctrl.md
DMA_RX_CTRL -- requirements
Module: dma_rx_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16: number of 128-bit entries in the receive buffer (power of two, at least 2).
REQ-002 SHALL have parameter MAX_BEATS, default 32768: maximum number of stream beats accepted per frame.
REQ-003 SHALL have port pl_clk, input, width 1: single clock for all logic.
REQ-004 SHALL have port nreset, input, width 1: reset, asynchronous, active-low.
REQ-005 SHALL have port fifo_reset, input, width 1: synchronous clear of the buffer, the packer and the FSM.
REQ-006 SHALL have port dma_start, input, width 1: receive enable level from the CPU.
REQ-007 SHALL have port s_tdata, input, width 32: AXI-Stream slave data from the DMA (MM2S).
REQ-008 SHALL have port s_tkeep, input, width 4: byte enables.
REQ-009 SHALL have port s_tlast, input, width 1: last beat of a frame.
REQ-010 SHALL have port s_tvalid, input, width 1: beat valid.
REQ-011 SHALL have port s_tready, output, width 1: beat accept.
REQ-012 SHALL have port dma_out, output, width 128: head-of-buffer word for the CPU.
REQ-013 SHALL have port dma_valid, output, width 1: buffer not empty.
REQ-014 SHALL have port dma_re, input, width 1: CPU pop strobe.
REQ-015 SHALL have port word_count, output, width 32: count of 128-bit words pushed.
REQ-016 SHALL have port frame_err, output, width 1: sticky protocol-error flag.
REQ-017 SHALL have port led, output, width 12: status bits.

Function
REQ-018 FSM SHALL have states IDLE=0, RECV=1, DONE=2; encoding 3 SHALL return to IDLE on the next cycle.
REQ-019 Transitions SHALL be: IDLE->RECV when dma_start=1; RECV->DONE on an accepted beat with s_tlast=1 or on the MAX_BEATS-th accepted beat; RECV->IDLE when dma_start=0; DONE->IDLE when dma_start=0.
REQ-020 s_tready SHALL equal (state==RECV) && dma_start && !fifo_full, computed combinationally from registered state.
REQ-021 A beat SHALL be accepted only when s_tvalid && s_tready; data SHALL NOT be sampled otherwise.
REQ-022 The packer SHALL place beat n of a word into lane n (lane 0 = dma_out[31:0], lane 3 = dma_out[127:96]), using a 2-bit lane counter.
REQ-023 The word SHALL be pushed on the clock edge accepting lane 3, or on the edge accepting a tlast/MAX_BEATS beat; unfilled lanes SHALL be zero; the lane counter SHALL then clear.
REQ-024 Push-to-dma_valid latency SHALL be 1 cycle; the buffer SHALL be first-word-fall-through.
REQ-025 Pop SHALL occur when dma_re && dma_valid; dma_re on empty SHALL be ignored.
REQ-026 Simultaneous push and pop SHALL both occur, and occupancy SHALL be unchanged.
REQ-027 Overflow SHALL be impossible because s_tready=0 while full.
REQ-028 Leaving RECV for IDLE SHALL discard a partially filled word without pushing it.
REQ-029 frame_err SHALL set on an accepted beat with s_tkeep!=4'hF, or on reaching MAX_BEATS without tlast; it SHALL clear only on reset or fifo_reset.
REQ-030 word_count SHALL increment by 1 per push and wrap modulo 2^32; fifo_reset SHALL NOT clear it.
REQ-031 led SHALL be {word_count[3:0], state[1:0], fifo_full, !dma_valid, dma_start, s_tvalid, s_tready, frame_err}.
REQ-032 fifo_reset SHALL take priority over every other event in the same cycle: it clears the buffer, the lane counter and frame_err, and sets state to IDLE.

Reset
REQ-033 While nreset=0 the block SHALL drive state=IDLE, empty buffer, lane=0, word_count=0, frame_err=0, s_tready=0, dma_valid=0 and dma_out=0.
REQ-034 Reset asserted mid-frame SHALL drop all buffered and partial data; after release the block SHALL wait in IDLE for dma_start.

Structure
REQ-035 A shared package SHALL hold the state encodings, the lane width (32) and the word width (128).
REQ-036 The buffer SHALL be one sub-module, sync_fifo128 (parameter DEPTH; ports push, pop, din, dout, full, empty, clear); the FSM and packer SHALL live in dma_rx_ctrl.

Verification
REQ-037 dma_start=1, 8 beats 0x1..0x8 with tlast on beat 8 -> two words 0x00000004_00000003_00000002_00000001 and 0x8..0x5, word_count=2, state=DONE.
REQ-038 6 beats with tlast on beat 6 -> second word = 0x00000000_00000000_00000006_00000005.
REQ-039 dma_re=0 and a continuous stream -> after 16 words s_tready=0; one pop -> s_tready=1 on the next cycle with no beat lost.
REQ-040 dma_start dropped after 2 beats -> no push, state=IDLE, and the next frame starts at lane 0.
REQ-041 A beat with s_tkeep=4'h7 -> frame_err=1 and held; fifo_reset pulse -> frame_err=0, dma_valid=0.
REQ-042 nreset asserted mid-frame with 3 words buffered -> dma_valid=0, word_count=0 immediately.
